// File: rtl/pc_pkg.sv
// Shared definitions for the program counter front end: the per-cycle
// action encoding and the default address width.
package pc_pkg;

   localparam int PC_ADDR_W = 16;

   typedef enum logic [2:0] {
      PC_OP_RESET,
      PC_OP_IRQ,
      PC_OP_RECOVER,
      PC_OP_SET,
      PC_OP_HOLD,
      PC_OP_INC
   } pc_op_t;

   // Exactly one action per cycle: reset > interrupt > recovery > set > lock > increment.
   function automatic pc_op_t pc_decode(input logic rst,
                                        input logic irq,
                                        input logic recover,
                                        input logic set,
                                        input logic lock);
      if (rst)          return PC_OP_RESET;
      else if (irq)     return PC_OP_IRQ;
      else if (recover) return PC_OP_RECOVER;
      else if (set)     return PC_OP_SET;
      else if (lock)    return PC_OP_HOLD;
      else              return PC_OP_INC;
   endfunction

endpackage

// File: rtl/pc_save_stack.sv
// LIFO of saved return addresses. The parent never pushes and pops in the
// same cycle; requests against a full/empty stack are ignored here.
module pc_save_stack
   import pc_pkg::*;
#(
   parameter int  ADDR_W  = PC_ADDR_W,
   parameter int  DEPTH   = 4,
   localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [ADDR_W-1:0]  data_in,
   output logic [ADDR_W-1:0]  data_out,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               empty
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0] mem [DEPTH];

   assign full  = (depth == DEPTH_W'(DEPTH));
   assign empty = (depth == '0);

   // Stale entries above the fill level are masked so they never reach the output.
   assign data_out = empty ? '0 : mem[IDX_W'(depth - DEPTH_W'(1))];

   always_ff @(posedge clk) begin
      if (rst) begin
         depth <= '0;
         // NOTE: the storage array is cleared on reset so no previous context survives it.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !full) begin
         // NOTE: non-blocking assignments keep every register update tied to the same edge.
         mem[IDX_W'(depth)] <= data_in;
         depth              <= depth + DEPTH_W'(1);
      end else if (pop && !empty) begin
         depth <= depth - DEPTH_W'(1);
      end
   end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with nested-interrupt return stack: picks the next fetch
// address each cycle and tracks sticky stack overflow/underflow.
module program_counter_stack
   import pc_pkg::*;
#(
   parameter int              ADDR_W     = PC_ADDR_W,
   parameter int              DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int              STEP       = 1,
   localparam int             DEPTH_W    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_set_enable,
   input  logic [ADDR_W-1:0]  i_set_address,
   input  logic               i_interrupt_enable,
   input  logic [ADDR_W-1:0]  i_interrupt_address,
   input  logic               i_recovery_enable,
   input  logic               i_lock,
   input  logic               i_address_en,
   output logic [ADDR_W-1:0]  o_address,
   output logic [ADDR_W-1:0]  o_save_top,
   output logic [DEPTH_W-1:0] o_depth,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_overflow,
   output logic               o_underflow
);

   pc_op_t            op;
   logic [ADDR_W-1:0] pc;
   logic              push;
   logic              pop;

   // NOTE: every combinational output gets a value on every path, so no latch is inferred.
   always_comb begin
      op   = pc_decode(rst, i_interrupt_enable, i_recovery_enable, i_set_enable, i_lock);
      push = (op == PC_OP_IRQ)     && !o_full;
      pop  = (op == PC_OP_RECOVER) && !o_empty;
   end

   pc_save_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_save_stack (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .data_in  (pc),
      .data_out (o_save_top),
      .depth    (o_depth),
      .full     (o_full),
      .empty    (o_empty)
   );

   always_ff @(posedge clk) begin
      case (op)
         PC_OP_RESET: begin
            pc          <= RESET_ADDR;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
         end
         // A rejected interrupt or recovery still consumes the cycle: pc holds.
         PC_OP_IRQ: begin
            if (o_full) o_overflow <= 1'b1;
            else        pc         <= i_interrupt_address;
         end
         PC_OP_RECOVER: begin
            if (o_empty) o_underflow <= 1'b1;
            else         pc          <= o_save_top;
         end
         PC_OP_SET:  pc <= i_set_address;
         PC_OP_HOLD: pc <= pc;
         default:    pc <= pc + ADDR_W'(STEP);
      endcase
   end

   assign o_address = i_address_en ? pc : '0;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench: a queue-based model checked every cycle, plus literal
// expectations on the hand-computed sequence points.
module tb_program_counter_stack;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_set_enable;
   logic [ADDR_W-1:0] i_set_address;
   logic              i_interrupt_enable;
   logic [ADDR_W-1:0] i_interrupt_address;
   logic              i_recovery_enable;
   logic              i_lock;
   logic              i_address_en;
   logic [ADDR_W-1:0] o_address;
   logic [ADDR_W-1:0] o_save_top;
   logic [2:0]        o_depth;
   logic              o_full;
   logic              o_empty;
   logic              o_overflow;
   logic              o_underflow;

   int errors = 0;
   int checks = 0;

   program_counter_stack #(
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .RESET_ADDR (16'h0000),
      .STEP       (1)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_set_enable        (i_set_enable),
      .i_set_address       (i_set_address),
      .i_interrupt_enable  (i_interrupt_enable),
      .i_interrupt_address (i_interrupt_address),
      .i_recovery_enable   (i_recovery_enable),
      .i_lock              (i_lock),
      .i_address_en        (i_address_en),
      .o_address           (o_address),
      .o_save_top          (o_save_top),
      .o_depth             (o_depth),
      .o_full              (o_full),
      .o_empty             (o_empty),
      .o_overflow          (o_overflow),
      .o_underflow         (o_underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pc as a number, the save stack as a queue.
   logic [ADDR_W-1:0] m_pc;
   logic [ADDR_W-1:0] m_stk[$];
   logic              m_ovf;
   logic              m_unf;

   always @(posedge clk) begin
      if (rst) begin
         m_pc  = 16'h0000;
         m_stk.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (i_interrupt_enable) begin
         if (m_stk.size() == DEPTH) m_ovf = 1'b1;
         else begin
            m_stk.push_back(m_pc);
            m_pc = i_interrupt_address;
         end
      end else if (i_recovery_enable) begin
         if (m_stk.size() == 0) m_unf = 1'b1;
         else m_pc = m_stk.pop_back();
      end else if (i_set_enable) begin
         m_pc = i_set_address;
      end else if (!i_lock) begin
         m_pc = m_pc + 16'd1;
      end
      #1;
      check("model_address", o_address, i_address_en ? m_pc : 16'h0000);
      check("model_save_top", o_save_top, (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : 16'h0000);
      check("model_depth", o_depth, m_stk.size());
      check("model_full", o_full, m_stk.size() == DEPTH);
      check("model_empty", o_empty, m_stk.size() == 0);
      check("model_overflow", o_overflow, m_ovf);
      check("model_underflow", o_underflow, m_unf);
   end

   // One cycle: drive on the falling edge, return shortly after the rising edge.
   task automatic cyc(input logic r, input logic irq, input logic rec, input logic set,
                      input logic lock, input logic en,
                      input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] sa);
      @(negedge clk);
      rst                 = r;
      i_interrupt_enable  = irq;
      i_recovery_enable   = rec;
      i_set_enable        = set;
      i_lock              = lock;
      i_address_en        = en;
      i_interrupt_address = ia;
      i_set_address       = sa;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; i_interrupt_enable = 1'b0; i_recovery_enable = 1'b0;
      i_set_enable = 1'b0; i_lock = 1'b0; i_address_en = 1'b1;
      i_interrupt_address = '0; i_set_address = '0;

      cyc(1, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      check("reset_address", o_address, 16'h0000);
      check("reset_empty", o_empty, 1);
      check("reset_full", o_full, 0);
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
         check("inc_address", o_address, i);
      end
      cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      for (int i = 1; i <= 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
         check("gated_address", o_address, 16'h0000);
      end

      // Two-level nesting and unwind.
      cyc(0, 0, 0, 1, 0, 1, 16'h0, 16'h0010);
      cyc(0, 1, 0, 0, 0, 1, 16'h0100, 16'h0);
      check("irq1_top", o_save_top, 16'h0010);
      cyc(0, 1, 0, 0, 0, 1, 16'h0200, 16'h0);
      check("irq2_address", o_address, 16'h0200);
      check("irq2_depth", o_depth, 2);
      check("irq2_top", o_save_top, 16'h0100);
      cyc(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
      check("rec1_address", o_address, 16'h0100);
      cyc(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
      check("rec2_address", o_address, 16'h0010);
      check("rec2_empty", o_empty, 1);

      // Fill to DEPTH then overflow.
      for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 0, 0, 1, 16'(i * 16'h1000), 16'h0);
      check("ovf_flag", o_overflow, 1);
      check("ovf_address", o_address, 16'h4000);
      check("ovf_depth", o_depth, 4);
      check("ovf_top", o_save_top, 16'h3000);
      cyc(0, 0, 0, 0, 1, 1, 16'h0, 16'h0);
      check("ovf_sticky", o_overflow, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
      check("unwind_address", o_address, 16'h0010);

      // Underflow, then set with lock.
      cyc(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
      check("unf_flag", o_underflow, 1);
      check("unf_address", o_address, 16'h0010);
      check("unf_ovf_still", o_overflow, 1);
      cyc(0, 0, 0, 1, 1, 1, 16'h0, 16'h1234);
      check("set_lock_address", o_address, 16'h1234);
      cyc(0, 0, 0, 0, 1, 1, 16'h0, 16'h0);
      check("lock_address", o_address, 16'h1234);

      // Wrap, then simultaneous interrupt and recovery.
      cyc(0, 0, 0, 1, 0, 1, 16'h0, 16'hFFFF);
      cyc(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      check("wrap_address", o_address, 16'h0000);
      cyc(0, 1, 0, 0, 0, 1, 16'h0500, 16'h0);
      cyc(0, 1, 1, 0, 0, 1, 16'h0600, 16'h0);
      check("irq_rec_depth", o_depth, 2);
      check("irq_rec_address", o_address, 16'h0600);
      check("irq_rec_top", o_save_top, 16'h0500);
      cyc(0, 1, 0, 0, 0, 1, 16'h0700, 16'h0);
      check("pre_rst_depth", o_depth, 3);

      // Reset mid-nesting.
      cyc(1, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      check("rst_depth", o_depth, 0);
      check("rst_address", o_address, 16'h0000);
      check("rst_top", o_save_top, 16'h0000);
      check("rst_overflow", o_overflow, 0);
      check("rst_underflow", o_underflow, 0);
      cyc(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
      check("post_rst_top", o_save_top, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
